// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester handshakes and the data-memory port served by dmem_arbiter.
// The arbiter binds the slave modport; the requesters and the memory together form the master side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    // Handshake: a requester raises reqN with stable weN/addrN/wdataN and holds it until it sees
    // the one-cycle ackN pulse, dropping req at that same edge; rdata is valid only while an ack is high.
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  m_rdata,
        output ack0, ack1, rdata, busy,
        output m_read, m_write, m_addr, m_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output m_rdata,
        input  ack0, ack1, rdata, busy,
        input  m_read, m_write, m_addr, m_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory: IDLE -> ACCESS -> DONE.
// Define DMEM_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_arbiter_if.slave        bus,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                we_l_q, we_l_d;
    logic [ADDR_W-1:0]   addr_l_q, addr_l_d;
    logic [DATA_W-1:0]   wdata_l_q, wdata_l_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                gnt_q, gnt_d;
    logic                last_grant_q, last_grant_d;

    logic                win;
    logic                m_read_c;
    logic                m_write_c;
    logic                ack0_c;
    logic                ack1_c;

    // Winner among the live requests; only consulted in IDLE when at least one req is high.
    always_comb begin
        win = 1'b0;
`ifdef DMEM_ARB_RR_EN
        if (bus.req0 && bus.req1) begin
            win = ~last_grant_q;
        end else begin
            win = bus.req1 && !bus.req0;
        end
`else
        win = !bus.req0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        we_l_d       = we_l_q;
        addr_l_d     = addr_l_q;
        wdata_l_d    = wdata_l_q;
        rdata_d      = rdata_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        m_read_c     = 1'b0;
        m_write_c    = 1'b0;
        ack0_c       = 1'b0;
        ack1_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d      = ACCESS;
                    gnt_d        = win;
                    last_grant_d = win;
                    we_l_d       = win ? bus.we1    : bus.we0;
                    addr_l_d     = win ? bus.addr1  : bus.addr0;
                    wdata_l_d    = win ? bus.wdata1 : bus.wdata0;
                end
            end
            ACCESS: begin
                // Strobes come from registered state only, so a reset here kills the write at once.
                m_read_c  = !we_l_q;
                m_write_c = we_l_q;
                if (!we_l_q) begin
                    rdata_d = bus.m_rdata;
                end
                state_d = DONE;
            end
            DONE: begin
                ack0_c  = !gnt_q;
                ack1_c  = gnt_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_l_q       <= 1'b0;
            addr_l_q     <= '0;
            wdata_l_q    <= '0;
            rdata_q      <= '0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            we_l_q       <= we_l_d;
            addr_l_q     <= addr_l_d;
            wdata_l_q    <= wdata_l_d;
            rdata_q      <= rdata_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.ack0    = ack0_c;
    assign bus.ack1    = ack1_c;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.m_read  = m_read_c;
    assign bus.m_write = m_write_c;
    assign bus.m_addr  = addr_l_q;
    assign bus.m_wdata = wdata_l_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter with a transaction-level reference model.
// Build with +define+DMEM_ARB_RR_EN to check the round-robin variant.
module tb_dmem_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    dbg_state;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- memory device and reference copy ----------------
  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];
  logic          pre_fill = 1'b0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  function automatic logic [DW-1:0] fill_val(input int i);
    return 32'(i) * 32'h0100_0193 + 32'h0000_0011;
  endfunction

  assign bus.m_rdata = mem[bus.m_addr];

  always @(posedge clk) begin
    if (bus.m_write) mem[bus.m_addr] <= bus.m_wdata;
    else if (pre_fill) for (int i = 0; i < 64; i++) mem[i] <= fill_val(i);
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int miscompares = 0;
  logic          exp_last;
  logic [DW-1:0] model_rdata;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule from the requester point of view.
  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return RR ? ~last : 1'b0;
    return r1 && !r0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit p, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (!p) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    step();
    pre_we = 1'b0;
  endtask

  function automatic logic cur_req(input bit p);
    return p ? bus.req1 : bus.req0;
  endfunction

  // One isolated transaction from a single requester, checked cycle by cycle.
  task automatic single(input bit p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag);
    logic [DW-1:0] exp_rd;
    exp_rd = w ? model_rdata : ref_mem[a];
    drive(p, 1'b1, w, a, d);
    step();
    check({tag, "_acc_mread"}, bus.m_read, !w);
    check({tag, "_acc_mwrite"}, bus.m_write, w);
    check({tag, "_acc_maddr"}, bus.m_addr, a);
    if (w) check({tag, "_acc_mwdata"}, bus.m_wdata, d);
    check({tag, "_acc_busy"}, bus.busy, 1'b1);
    check({tag, "_acc_noack"}, {bus.ack0, bus.ack1}, 2'b00);
    drive(p, 1'b1, ~w, AW'(a + 1), ~d);
    step();
    check({tag, "_done_strobes"}, {bus.m_read, bus.m_write}, 2'b00);
    check({tag, "_done_ack0"}, bus.ack0, !p);
    check({tag, "_done_ack1"}, bus.ack1, p);
    check({tag, "_done_rdata"}, bus.rdata, exp_rd);
    if (w) ref_mem[a] = d;
    else model_rdata = exp_rd;
    exp_last = p;
    drive(p, 1'b0, 1'b0, '0, '0);
    step();
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
    check({tag, "_idle_ack"}, {bus.ack0, bus.ack1}, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic          w, lastm, wl;
    int            edge_n, acc_edge, next_free;
    bit            pend [2];
    logic          acc_p, acc_we, in_acc, in_done;
    logic [AW-1:0] acc_a;
    logic [DW-1:0] acc_d, acc_rd;

    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    pre_fill = 1'b1;
    @(negedge clk);
    pre_fill = 1'b0;

    // Reset state
    check("rst_acks", {bus.ack0, bus.ack1}, 2'b00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_strobes", {bus.m_read, bus.m_write}, 2'b00);
    check("rst_rdata", bus.rdata, '0);
    check("rst_maddr", bus.m_addr, '0);
    check("rst_mwdata", bus.m_wdata, '0);
    check("rst_state", dbg_state, 2'd0);

    poke(6'd1, 32'd7);
    poke(6'd2, 32'd22);
    for (int i = 0; i < 64; i++) ref_mem[i] = fill_val(i);
    ref_mem[1] = 32'd7;
    ref_mem[2] = 32'd22;
    rst_n = 1'b1;
    exp_last = 1'b1;
    model_rdata = '0;
    step();

    // Read on port 0, write then read on port 1
    single(1'b0, 1'b0, 6'd1, '0, "rd0");
    single(1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF, "wr1");
    single(1'b1, 1'b0, 6'd5, '0, "rd1");

    // Both requesting continuously: acks every 3 cycles, winners per arbitration rule
    drive(1'b0, 1'b1, 1'b0, 6'd1, '0);
    drive(1'b1, 1'b1, 1'b0, 6'd5, '0);
    lastm = exp_last;
    for (int k = 0; k < 4; k++) begin
      lastm = pick(1'b1, 1'b1, lastm);
      exp_q.push_back({31'd0, lastm});
    end
    wl = 1'b0;
    for (int s = 1; s <= 11; s++) begin
      step();
      if (s % 3 == 2) begin
        w = exp_q.pop_front()[0];
        wl = w;
        check("tie_ack0", bus.ack0, !w);
        check("tie_ack1", bus.ack1, w);
        check("tie_rdata", bus.rdata, w ? ref_mem[5] : ref_mem[1]);
      end else begin
        check("tie_gap_ack", {bus.ack0, bus.ack1}, 2'b00);
      end
    end
    exp_last = wl;
    drive(wl, 1'b0, 1'b0, '0, '0);
    for (int s = 1; s <= 3; s++) begin
      step();
      if (s == 3) begin
        check("tie_other_ack0", bus.ack0, wl);
        check("tie_other_ack1", bus.ack1, !wl);
      end else begin
        check("tie_other_wait", {bus.ack0, bus.ack1}, 2'b00);
      end
    end
    model_rdata = wl ? ref_mem[1] : ref_mem[5];
    exp_last = !wl;
    drive(!wl, 1'b0, 1'b0, '0, '0);
    step();
    check("tie_end_busy", bus.busy, 1'b0);

    // Reset during the ACCESS cycle of a write to addr 2
    drive(1'b0, 1'b1, 1'b1, 6'd2, 32'h0000_0055);
    step();
    check("mrst_acc_mwrite", bus.m_write, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_mwrite", bus.m_write, 1'b0);
    check("mrst_acks", {bus.ack0, bus.ack1}, 2'b00);
    check("mrst_busy", bus.busy, 1'b0);
    check("mrst_mread", bus.m_read, 1'b0);
    check("mrst_maddr", bus.m_addr, '0);
    check("mrst_mwdata", bus.m_wdata, '0);
    check("mrst_rdata", bus.rdata, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_last = 1'b1;
    model_rdata = '0;
    step();
    check("mrst_after_ack", {bus.ack0, bus.ack1}, 2'b00);
    step();
    check("mrst_mem2", mem[2], ref_mem[2]);

    // Port 1 arrives during port 0's ACCESS
    drive(1'b0, 1'b1, 1'b1, 6'd9, 32'hCAFE_0009);
    step();
    check("late_acc_mwrite", bus.m_write, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 6'd9, '0);
    step();
    check("late_ack0", {bus.ack0, bus.ack1}, 2'b10);
    ref_mem[9] = 32'hCAFE_0009;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    step();
    check("late_idle", {bus.busy, bus.ack1}, 2'b00);
    step();
    check("late_acc_mread", bus.m_read, 1'b1);
    check("late_acc_maddr", bus.m_addr, 6'd9);
    step();
    check("late_ack1", {bus.ack0, bus.ack1}, 2'b01);
    check("late_rdata", bus.rdata, 32'hCAFE_0009);
    model_rdata = 32'hCAFE_0009;
    exp_last = 1'b1;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    step();

    // Randomized traffic against the transaction-level model
    edge_n = 0; acc_edge = -100; next_free = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    acc_p = 1'b0; acc_we = 1'b0; acc_a = '0; acc_d = '0; acc_rd = '0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      edge_n++;
      if (edge_n >= next_free && (bus.req0 || bus.req1)) begin
        acc_p = pick(bus.req0, bus.req1, exp_last);
        exp_last = acc_p;
        acc_we = acc_p ? bus.we1 : bus.we0;
        acc_a = acc_p ? bus.addr1 : bus.addr0;
        acc_d = acc_p ? bus.wdata1 : bus.wdata0;
        if (acc_we) begin
          ref_mem[acc_a] = acc_d;
          acc_rd = model_rdata;
        end else begin
          acc_rd = ref_mem[acc_a];
          model_rdata = acc_rd;
        end
        acc_edge = edge_n;
        next_free = edge_n + 3;
        pend[acc_p] = 1'b1;
      end
      @(negedge clk);
      in_acc = (edge_n == acc_edge);
      in_done = (edge_n == acc_edge + 1);
      check("rnd_mread", bus.m_read, in_acc && !acc_we);
      check("rnd_mwrite", bus.m_write, in_acc && acc_we);
      check("rnd_busy", bus.busy, in_acc || in_done);
      check("rnd_ack0", bus.ack0, in_done && !acc_p);
      check("rnd_ack1", bus.ack1, in_done && acc_p);
      if (in_acc) check("rnd_maddr", bus.m_addr, acc_a);
      if (in_acc && acc_we) check("rnd_mwdata", bus.m_wdata, acc_d);
      if (in_done) check("rnd_rdata", bus.rdata, acc_rd);
      for (int p = 0; p < 2; p++) begin
        if (in_done && acc_p == 1'(p)) begin
          pend[p] = 1'b0;
          if ($urandom_range(0, 2) == 0)
            drive(1'(p), 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
          else
            drive(1'(p), 1'b0, 1'b0, '0, '0);
        end else if (pend[p]) begin
          if ($urandom_range(0, 1) == 1)
            drive(1'(p), 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        end else if (!cur_req(1'(p)) && $urandom_range(0, 3) == 0) begin
          drive(1'(p), 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    for (int s = 0; s < 4; s++) step();
    check("end_busy", bus.busy, 1'b0);
    for (int i = 0; i < 64; i++) check($sformatf("mem_%0d", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 64x32 data memory.
- Requester 0 is the CPU load/store stage; requester 1 is the debug/program loader.
- Registers the winning request, drives MemRead/MemWrite/addr/data_in for one cycle, captures data_out, and returns a one-cycle ack with read data.
- Sits between the requesters and the data memory; the memory is the only consumer of the m_* outputs.

Parameters:
- ADDR_W, 6, word address width (64 words)
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 access request; held high until ack0
- we0  in  1  requester 0: 1 = write, 0 = read
- addr0  in  ADDR_W  requester 0 word address
- wdata0  in  DATA_W  requester 0 write data
- ack0  out  1  one-cycle completion pulse for requester 0
- req1 / we1 / addr1 / wdata1 / ack1  as above, for requester 1
- rdata  out  DATA_W  read data; valid while ack0 or ack1 is high
- busy  out  1  high in ACCESS and DONE
- m_read  out  1  memory MemRead
- m_write  out  1  memory MemWrite
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory data_out (combinational read)

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; ack0, ack1, busy, m_read, m_write = 0
  - rdata, m_addr, m_wdata = 0; last_grant = 1
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If req0 or req1 is high, select a winner, latch its we/addr/wdata and grant id, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly one cycle):
  - m_read = ~we_l, m_write = we_l; m_addr and m_wdata come from the latched registers.
  - m_read and m_write are decoded from the state register only, never from live req inputs.
  - On a read, the next edge captures m_rdata into rdata.
  - On a write, rdata is left unchanged.
  - Go to DONE.
- DONE (one cycle):
  - ack of the granted port = 1; m_read = m_write = 0.
  - Go to IDLE.
- Latency: req sampled at edge N; memory access in cycle N+1; ack high in cycle N+2. A new request is accepted at the earliest at edge N+3.
- Handshake:
  - A requester drops req at the edge where it sees ack. If req is still high at that edge, it is treated as a new request.
  - req/addr/wdata changes after acceptance are ignored, because the request is latched.
- Arbitration: see Optional Feature. last_grant updates on every acceptance.
- Requests are only evaluated in IDLE. A request arriving during ACCESS or DONE waits without loss.
- Only one m_read or m_write pulse per accepted request. No write ever occurs without a grant.
- Reset mid-operation:
  - m_write and ack clear immediately (asynchronous).
  - Any in-flight request is discarded without an ack; the requester must re-issue.
  - A write in ACCESS that has not reached its edge is not performed.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both ports request in IDLE, the winner is the port not equal to last_grant. A single requester always wins. After reset, port 0 wins the first tie.
- Undefined: fixed priority. Port 0 always wins ties; last_grant is still maintained but does not affect selection.

Test Plan:
- Read port 0: memory preloaded mem[1]=7; req0=1, we0=0, addr0=1 at edge 0 -> m_read=1 in cycle 1; ack0=1 and rdata=7 in cycle 2; ack1 stays 0.
- Write then read port 1: we1=1, addr1=5, wdata1=0xDEADBEEF -> m_write=1 for exactly one cycle; ack1 in cycle 2. Then a read of addr 5 -> rdata=0xDEADBEEF.
- Tie with DMEM_ARB_RR_EN defined: req0 and req1 held high continuously -> grants alternate 0,1,0,1 and each ack arrives 3 cycles apart.
- Tie with DMEM_ARB_RR_EN undefined: both requesting, and port 0 re-requests immediately after each ack -> port 1 waits until req0 drops.
- Mid-operation reset: rst_n low during ACCESS of a write to addr 2 (old value 22) -> m_write drops immediately, no ack, mem[2] still 22, all outputs 0.
- Late arrival: req1 rises during port 0's ACCESS -> port 1 is accepted in the first IDLE after port 0's ack, with correct data.
